// File: rtl/cordic_sweep_if.sv
`default_nettype none
// ============================================================================
//  Module   : cordic_sweep_if
//  Brief    : Control/status bundle between the register block and the sweep
//             scheduler that feeds the CORDIC step generator.
//  Revision : 1.0
// ============================================================================
interface cordic_sweep_if #(
    parameter int STEP_W  = 32,
    parameter int DWELL_W = 16
);
    logic               start;
    logic               abort;
    logic [1:0]         mode;
    logic [STEP_W-1:0]  step_start;
    logic [STEP_W-1:0]  step_stop;
    logic [STEP_W-1:0]  step_inc;
    logic [DWELL_W-1:0] dwell;
    logic [STEP_W-1:0]  step;
    logic               step_valid;
    logic               busy;
    logic               done;
    logic               dir;

    modport master (
        output start, abort, mode, step_start, step_stop, step_inc, dwell,
        input  step, step_valid, busy, done, dir
    );

    modport slave (
        input  start, abort, mode, step_start, step_stop, step_inc, dwell,
        output step, step_valid, busy, done, dir
    );
endinterface

`default_nettype wire

// File: rtl/cordic_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cordic_sweep_ctrl
//  Brief    : Staircase frequency-sweep scheduler (single / repeat / up-down)
//             driving the phase-increment word of the CORDIC step generator.
//  Revision : 1.0
// ============================================================================
module cordic_sweep_ctrl #(
    parameter int STEP_W  = 32,
    parameter int DWELL_W = 16
) (
    input  wire logic           clk,
    input  wire logic           rst,
    cordic_sweep_if.slave       sw
);
    localparam logic [DWELL_W-1:0] c_DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};
    localparam logic [1:0]         c_MODE_REP  = 2'd1;
    localparam logic [1:0]         c_MODE_UD   = 2'd2;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state, w_state;
    logic [STEP_W-1:0]  r_step, w_step;
    logic               r_valid, w_valid;
    logic               r_done, w_done;
    logic               r_dir, w_dir;
    logic               r_fwd, w_fwd;
    logic [DWELL_W-1:0] r_cnt, w_cnt;
    logic [STEP_W-1:0]  r_cfg_start, w_cfg_start;
    logic [STEP_W-1:0]  r_cfg_stop, w_cfg_stop;
    logic [STEP_W-1:0]  r_cfg_inc, w_cfg_inc;
    logic [DWELL_W-1:0] r_cfg_dwell, w_cfg_dwell;
    logic [1:0]         r_cfg_mode, w_cfg_mode;
    logic [STEP_W-1:0]  w_target;
    logic [STEP_W-1:0]  w_rev_target;

    // One stride toward tgt, clamped so the word never passes or wraps past it.
    function automatic logic [STEP_W-1:0] f_stride(
        input logic [STEP_W-1:0] cur,
        input logic [STEP_W-1:0] inc,
        input logic [STEP_W-1:0] tgt,
        input logic              down
    );
        logic [STEP_W:0] v;
        if (!down) begin
            v = {1'b0, cur} + {1'b0, inc};
            if (v > {1'b0, tgt}) v = {1'b0, tgt};
        end else begin
            v = {1'b0, cur} - {1'b0, inc};
            if (v[STEP_W] || (v < {1'b0, tgt})) v = {1'b0, tgt};
        end
        return v[STEP_W-1:0];
    endfunction

    // r_fwd marks the start->stop segment; up-down flips it at each endpoint.
    assign w_target     = r_fwd ? r_cfg_stop  : r_cfg_start;
    assign w_rev_target = r_fwd ? r_cfg_start : r_cfg_stop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_step      <= '0;
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
            r_dir       <= 1'b0;
            r_fwd       <= 1'b1;
            r_cnt       <= '0;
            r_cfg_start <= '0;
            r_cfg_stop  <= '0;
            r_cfg_inc   <= '0;
            r_cfg_dwell <= '0;
            r_cfg_mode  <= '0;
        end else begin
            r_state     <= w_state;
            r_step      <= w_step;
            r_valid     <= w_valid;
            r_done      <= w_done;
            r_dir       <= w_dir;
            r_fwd       <= w_fwd;
            r_cnt       <= w_cnt;
            r_cfg_start <= w_cfg_start;
            r_cfg_stop  <= w_cfg_stop;
            r_cfg_inc   <= w_cfg_inc;
            r_cfg_dwell <= w_cfg_dwell;
            r_cfg_mode  <= w_cfg_mode;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_step      = r_step;
        w_valid     = 1'b0;
        w_done      = 1'b0;
        w_dir       = r_dir;
        w_fwd       = r_fwd;
        w_cnt       = r_cnt;
        w_cfg_start = r_cfg_start;
        w_cfg_stop  = r_cfg_stop;
        w_cfg_inc   = r_cfg_inc;
        w_cfg_dwell = r_cfg_dwell;
        w_cfg_mode  = r_cfg_mode;

        case (r_state)
            S_IDLE: begin
                if (sw.start && !sw.abort) begin
                    w_cfg_start = sw.step_start;
                    w_cfg_stop  = sw.step_stop;
                    w_cfg_inc   = sw.step_inc;
                    w_cfg_dwell = sw.dwell;
                    w_cfg_mode  = sw.mode;
                    w_step      = sw.step_start;
                    w_valid     = 1'b1;
                    w_dir       = (sw.step_stop < sw.step_start);
                    w_fwd       = 1'b1;
                    w_cnt       = sw.dwell;
                    w_state     = S_RUN;
                end
            end
            S_RUN: begin
                if (sw.abort) begin
                    w_state = S_IDLE;
                end else if (r_cnt != '0) begin
                    w_cnt = r_cnt - c_DWELL_ONE;
                end else begin
                    w_cnt = r_cfg_dwell;
                    // A zero stride ends the segment at once, except in up-down
                    // where it freezes on the start value without toggling.
                    if ((r_step == w_target) ||
                        ((r_cfg_inc == '0) && (r_cfg_mode != c_MODE_UD))) begin
                        case (r_cfg_mode)
                            c_MODE_REP: begin
                                w_step  = r_cfg_start;
                                w_valid = 1'b1;
                            end
                            c_MODE_UD: begin
                                w_dir   = !r_dir;
                                w_fwd   = !r_fwd;
                                w_step  = f_stride(r_step, r_cfg_inc, w_rev_target, !r_dir);
                                w_valid = 1'b1;
                            end
                            default: begin
                                w_state = S_IDLE;
                                w_done  = 1'b1;
                            end
                        endcase
                    end else if (r_cfg_inc != '0) begin
                        w_step  = f_stride(r_step, r_cfg_inc, w_target, r_dir);
                        w_valid = 1'b1;
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign sw.step       = r_step;
    assign sw.step_valid = r_valid;
    assign sw.done       = r_done;
    assign sw.dir        = r_dir;
    assign sw.busy       = (r_state == S_RUN);

endmodule

`default_nettype wire

// File: tb/tb_cordic_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cordic_sweep_ctrl
//  Brief    : Scoreboard bench for cordic_sweep_ctrl: directed plus random
//             sweeps against a staircase trace model.
//  Revision : 1.0
// ============================================================================
module tb_cordic_sweep_ctrl;
    typedef struct packed {
        logic [31:0] step;
        logic        valid;
        logic        done;
        logic        busy;
        logic        dir;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cordic_sweep_if #(.STEP_W(32), .DWELL_W(16)) sif ();

    cordic_sweep_ctrl #(.STEP_W(32), .DWELL_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sif)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en   = 1'b0;
    rec_t exp_q[$];
    rec_t tr[$];

    // Model state between cycles
    bit          m_busy = 1'b0;
    int          m_idx  = 0;
    logic [31:0] m_last_step = '0;
    logic        m_last_dir  = 1'b0;

    function automatic rec_t cur_out();
        rec_t r;
        r.step  = sif.step;
        r.valid = sif.step_valid;
        r.done  = sif.done;
        r.busy  = sif.busy;
        r.dir   = sif.dir;
        return r;
    endfunction

    task automatic check(input string name, input rec_t act, input rec_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got step=%h valid=%0b done=%0b busy=%0b dir=%0b, expected step=%h valid=%0b done=%0b busy=%0b dir=%0b",
                     name, act.step, act.valid, act.done, act.busy, act.dir,
                     exp.step, exp.valid, exp.done, exp.busy, exp.dir);
        end
    endtask

    // Monitor: compares one queued expectation against the outputs after each edge.
    always begin
        @(posedge clk);
        #1;
        if (mon_en && exp_q.size() > 0) begin
            rec_t e;
            rec_t a;
            e = exp_q.pop_front();
            a = cur_out();
            check("sweep", a, e);
            n_checks++;
            if (a.valid && a.done) begin
                n_errors++;
                $display("FAIL excl: step_valid and done both high at %0t", $time);
            end
        end
    end

    function automatic logic [31:0] m_next(input logic [31:0] v, input logic [31:0] inc,
                                           input logic [31:0] tgt, input bit down);
        longint a;
        if (!down) begin
            a = longint'(v) + longint'(inc);
            if (a >= longint'(tgt)) return tgt;
        end else begin
            a = longint'(v) - longint'(inc);
            if (a <= longint'(tgt)) return tgt;
        end
        return a[31:0];
    endfunction

    task automatic emit(input logic [31:0] v, input bit down, input bit pulse, input logic [15:0] dw);
        for (int i = 0; i <= int'(dw); i++) begin
            rec_t r;
            r.step = v; r.valid = pulse && (i == 0); r.done = 1'b0; r.busy = 1'b1; r.dir = down;
            tr.push_back(r);
        end
    endtask

    // Expected per-cycle trace of a whole sweep, from the staircase rules.
    task automatic build(input logic [31:0] s, input logic [31:0] p, input logic [31:0] inc,
                         input logic [15:0] dw, input logic [1:0] md, input int need);
        bit          fwd    = 1'b1;
        bit          down   = (p < s);
        bit          single = (md == 2'd0) || (md == 2'd3);
        logic [31:0] v      = s;
        logic [31:0] tgt    = p;
        tr.delete();
        emit(v, down, 1'b1, dw);
        while (tr.size() < need) begin
            if (v != tgt && inc != 0) begin
                v = m_next(v, inc, tgt, down);
                emit(v, down, 1'b1, dw);
            end else if (v != tgt && md == 2'd2) begin
                emit(v, down, 1'b0, dw);
            end else if (single) begin
                rec_t r;
                r.step = v; r.valid = 1'b0; r.done = 1'b1; r.busy = 1'b0; r.dir = down;
                tr.push_back(r);
                break;
            end else if (md == 2'd1) begin
                v = s;
                emit(v, down, 1'b1, dw);
            end else begin
                down = !down;
                fwd  = !fwd;
                tgt  = fwd ? p : s;
                v    = m_next(v, inc, tgt, down);
                emit(v, down, 1'b1, dw);
            end
        end
    endtask

    function automatic rec_t idle_rec();
        rec_t r;
        r.step = m_last_step; r.valid = 1'b0; r.done = 1'b0; r.busy = 1'b0; r.dir = m_last_dir;
        return r;
    endfunction

    task automatic push_exp(input rec_t r);
        exp_q.push_back(r);
        m_last_step = r.step;
        m_last_dir  = r.dir;
    endtask

    task automatic scramble_cfg();
        sif.step_start = $urandom;
        sif.step_stop  = $urandom;
        sif.step_inc   = $urandom;
        sif.dwell      = 16'($urandom_range(0, 7));
        sif.mode       = 2'($urandom);
    endtask

    task automatic sweep(input logic [31:0] s, input logic [31:0] p, input logic [31:0] inc,
                         input logic [15:0] dw, input logic [1:0] md, input int run_cycles,
                         input int restart_at, input bit both_end);
        build(s, p, inc, dw, md, run_cycles + 2);
        @(negedge clk);
        sif.start = 1'b1; sif.abort = 1'b0;
        sif.step_start = s; sif.step_stop = p; sif.step_inc = inc; sif.dwell = dw; sif.mode = md;
        m_busy = 1'b1; m_idx = 0;
        push_exp(tr[0]);
        for (int c = 1; c < run_cycles; c++) begin
            bit ab;
            bit st;
            @(negedge clk);
            scramble_cfg();
            ab = m_busy && (c == run_cycles - 1);
            st = m_busy && ((c == restart_at) || (both_end && c == run_cycles - 1));
            if (!m_busy && ($urandom_range(0, 3) == 0)) ab = 1'b1;
            sif.start = st;
            sif.abort = ab;
            if (m_busy && ab) begin
                m_busy = 1'b0;
                push_exp(idle_rec());
            end else if (m_busy) begin
                m_idx++;
                push_exp(tr[m_idx]);
                if (tr[m_idx].done) m_busy = 1'b0;
            end else begin
                push_exp(idle_rec());
            end
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            scramble_cfg();
            sif.start = 1'b0;
            sif.abort = ($urandom_range(0, 1) == 0);
            push_exp(idle_rec());
        end
        @(negedge clk);
        sif.abort = 1'b0;
        push_exp(idle_rec());
    endtask

    initial begin
        rec_t zero_rec;
        zero_rec = '0;
        sif.start = 1'b0; sif.abort = 1'b0;
        sif.step_start = '0; sif.step_stop = '0; sif.step_inc = '0; sif.dwell = '0; sif.mode = '0;
        #1;
        check("reset_state", cur_out(), zero_rec);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        sweep(32'd100, 32'd130, 32'd10, 16'd2, 2'd0, 20, -1, 1'b0);
        sweep(32'd100, 32'd130, 32'd10, 16'd2, 2'd0, 5, -1, 1'b0);
        sweep(32'd25, 32'd0, 32'd10, 16'd1, 2'd0, 14, -1, 1'b0);
        sweep(32'hFFFF_FFE0, 32'hFFFF_FFFF, 32'h20, 16'd1, 2'd3, 10, -1, 1'b0);
        sweep(32'd0, 32'd20, 32'd10, 16'd0, 2'd2, 15, -1, 1'b0);
        sweep(32'd5, 32'd7, 32'd1, 16'd0, 2'd1, 12, -1, 1'b0);
        sweep(32'd42, 32'd90, 32'd0, 16'd3, 2'd0, 10, -1, 1'b0);
        sweep(32'd0, 32'd20, 32'd10, 16'd0, 2'd2, 10, -1, 1'b1);
        sweep(32'd100, 32'd130, 32'd10, 16'd2, 2'd0, 20, 4, 1'b0);
        sweep(32'd9, 32'd9, 32'd3, 16'd1, 2'd2, 10, -1, 1'b0);
        sweep(32'd9, 32'd50, 32'd0, 16'd1, 2'd2, 10, -1, 1'b0);
        sweep(32'd9, 32'd50, 32'd0, 16'd1, 2'd1, 10, -1, 1'b0);

        for (int n = 0; n < 30; n++) begin
            logic [31:0] s;
            logic [31:0] p;
            longint      pl;
            int          rc;
            s  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FF00 + 32'($urandom_range(0, 255))) : $urandom;
            pl = ($urandom_range(0, 1) == 0) ? longint'(s) + $urandom_range(0, 200)
                                             : longint'(s) - $urandom_range(0, 200);
            if (pl < 0) pl = 0;
            if (pl > 64'hFFFF_FFFF) pl = 64'hFFFF_FFFF;
            p  = pl[31:0];
            rc = $urandom_range(5, 60);
            sweep(s, p, 32'($urandom_range(0, 60)), 16'($urandom_range(0, 3)), 2'($urandom),
                  rc, $urandom_range(1, rc), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        mon_en = 1'b0;

        // Asynchronous reset in the middle of a running sweep.
        @(negedge clk);
        sif.step_start = 32'd5; sif.step_stop = 32'd7; sif.step_inc = 32'd1;
        sif.dwell = 16'd0; sif.mode = 2'd1; sif.start = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_reset", cur_out(), zero_rec);
        repeat (10) @(posedge clk);
        #1;
        check("reset_held", cur_out(), zero_rec);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("post_reset_idle", cur_out(), zero_rec);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end
endmodule

`default_nettype wire
